// File: rtl/fetch_npc_unit.sv
// IF stage and IF/ID pipeline register for the five-stage MIPS pipeline.
// Holds the fetch PC, selects the next PC (sequential, branch, j/jal, jr)
// and latches the fetched word plus its link values into ID. Redirects
// never flush: the word fetched alongside a branch/jump in ID is the
// architectural delay slot and proceeds normally.
module fetch_npc_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] IM_BYTES = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic [1:0]  NPCOp,
    input  logic        Branch,
    input  logic [25:0] Imm26,
    input  logic [31:0] RSData,
    input  logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] IR_D,
    output logic [31:0] PC4_D,
    output logic [31:0] PC8_D,
    output logic        AddrErr
);

    localparam logic [1:0] NpcSeq    = 2'b00;
    localparam logic [1:0] NpcBranch = 2'b01;
    localparam logic [1:0] NpcJump   = 2'b10;
    localparam logic [1:0] NpcJr     = 2'b11;

    // Upper bound of the fetch window, computed one bit wider so a window
    // ending exactly at 2^32 does not wrap to zero.
    localparam logic [32:0] WinLo = {1'b0, PC_RESET};
    localparam logic [32:0] WinHi = {1'b0, PC_RESET} + {1'b0, IM_BYTES};

    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] pc4_q, pc4_d;
    logic [31:0] pc8_q, pc8_d;
    logic        err_q, err_d;

    logic [31:0] pcf_plus4;
    logic [31:0] pcf_plus8;
    logic [31:0] branch_off;
    logic [31:0] branch_tgt;
    logic [31:0] jump_tgt;
    logic [31:0] jr_tgt;
    logic [31:0] npc;
    logic        fetch_bad;
    logic        jr_misaligned;
    logic [31:0] fetch_word;

    // Sequential and link increments of the current fetch address.
    always_comb begin
        pcf_plus4 = pc_q + 32'd4;
        pcf_plus8 = pc_q + 32'd8;
    end

    // Redirect targets, all relative to the ID instruction (PC4_D) or RSData.
    always_comb begin
        branch_off = {{14{Imm26[15]}}, Imm26[15:0], 2'b00};
        branch_tgt = pc4_q + branch_off;
        jump_tgt   = {pc4_q[31:28], Imm26, 2'b00};
        jr_tgt     = {RSData[31:2], 2'b00};
    end

    // Next-PC select; Branch only matters for the conditional branch op.
    always_comb begin
        npc = pcf_plus4;
        unique case (NPCOp)
            NpcSeq:    npc = pcf_plus4;
            NpcBranch: npc = Branch ? branch_tgt : pcf_plus4;
            NpcJump:   npc = jump_tgt;
            NpcJr:     npc = jr_tgt;
            default:   npc = pcf_plus4;
        endcase
    end

    // Fetch window / alignment check; an illegal fetch is replaced by a nop.
    always_comb begin
        fetch_bad     = ({1'b0, pc_q} < WinLo) || ({1'b0, pc_q} >= WinHi) ||
                        (pc_q[1:0] != 2'b00);
        jr_misaligned = (NPCOp == NpcJr) && (RSData[1:0] != 2'b00);
        fetch_word    = fetch_bad ? 32'h0000_0000 : InstrF;
    end

    // Next-state for the PC and IF/ID register; a stall freezes everything,
    // including any pending redirect and the error flag.
    always_comb begin
        pc_d  = pc_q;
        ir_d  = ir_q;
        pc4_d = pc4_q;
        pc8_d = pc8_q;
        err_d = err_q;
        if (!Stall) begin
            pc_d  = npc;
            ir_d  = fetch_word;
            pc4_d = pcf_plus4;
            pc8_d = pcf_plus8;
            err_d = err_q | fetch_bad | jr_misaligned;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q  <= PC_RESET;
            ir_q  <= 32'h0000_0000;
            pc4_q <= PC_RESET;
            pc8_q <= PC_RESET + 32'd4;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            pc4_q <= pc4_d;
            pc8_q <= pc8_d;
            err_q <= err_d;
        end
    end

    assign PCF     = pc_q;
    assign IR_D    = ir_q;
    assign PC4_D   = pc4_q;
    assign PC8_D   = pc8_q;
    assign AddrErr = err_q;

endmodule

// File: tb/tb_fetch_npc_unit.sv
// Directed bench for fetch_npc_unit: sequential fetch, taken/not-taken
// branch with delay slot, stalled branch, jr alignment, async reset during
// a stall, and an out-of-window jump.
module tb_fetch_npc_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [1:0]  npc_op;
    logic        branch;
    logic [25:0] imm26;
    logic [31:0] rs_data;
    logic [31:0] instr_f;
    logic [31:0] pcf;
    logic [31:0] ir_d;
    logic [31:0] pc4_d;
    logic [31:0] pc8_d;
    logic        addr_err;

    int checks = 0;
    int errors = 0;

    fetch_npc_unit #(
        .PC_RESET(32'h0000_3000),
        .IM_BYTES(32'h0000_1000)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .Stall  (stall),
        .NPCOp  (npc_op),
        .Branch (branch),
        .Imm26  (imm26),
        .RSData (rs_data),
        .InstrF (instr_f),
        .PCF    (pcf),
        .IR_D   (ir_d),
        .PC4_D  (pc4_d),
        .PC8_D  (pc8_d),
        .AddrErr(addr_err)
    );

    // Instruction memory stand-in: each word encodes its own address.
    assign instr_f = {16'hA5A5, pcf[15:0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ir,
                               input logic [31:0] e_pc4, input logic [31:0] e_err);
        check({tag, ".pcf"}, pcf, e_pc);
        check({tag, ".ir_d"}, ir_d, e_ir);
        check({tag, ".pc4_d"}, pc4_d, e_pc4);
        check({tag, ".pc8_d"}, pc8_d, e_pc4 + 32'd4);
        check({tag, ".err"}, {31'd0, addr_err}, e_err);
    endtask

    initial begin
        reset   = 1'b1;
        stall   = 1'b0;
        npc_op  = 2'b00;
        branch  = 1'b0;
        imm26   = 26'd0;
        rs_data = 32'd0;
        #1 reset = 1'b0;
        #1;
        check_state("rst", 32'h3000, 32'h0, 32'h3000, 0);
        step();
        check_state("rst_hold", 32'h3000, 32'h0, 32'h3000, 0);
        reset = 1'b1;

        // Sequential fetch.
        step();
        check_state("seq1", 32'h3004, 32'hA5A5_3000, 32'h3004, 0);
        step();
        check_state("seq2", 32'h3008, 32'hA5A5_3004, 32'h3008, 0);

        // Taken beq, PC4_D=0x3008, offset -2 words -> 0x3000; delay slot 0x3008 enters ID.
        npc_op = 2'b01; branch = 1'b1; imm26 = 26'h000_FFFE;
        step();
        check_state("br_taken", 32'h3000, 32'hA5A5_3008, 32'h300C, 0);

        // Not taken: sequential.
        branch = 1'b0;
        step();
        check_state("br_nt", 32'h3004, 32'hA5A5_3000, 32'h3004, 0);

        // j/jal-like op with Branch high ignores Branch only for op 01: seq op here.
        npc_op = 2'b00; branch = 1'b1;
        step();
        check_state("seq3", 32'h3008, 32'hA5A5_3004, 32'h3008, 0);

        // Branch under stall: everything holds, Branch toggling.
        npc_op = 2'b01; stall = 1'b1; branch = 1'b1;
        step();
        check_state("stall1", 32'h3008, 32'hA5A5_3004, 32'h3008, 0);
        branch = 1'b0;
        step();
        check_state("stall2", 32'h3008, 32'hA5A5_3004, 32'h3008, 0);
        stall = 1'b0; branch = 1'b1;
        step();
        check_state("stall_rel", 32'h3000, 32'hA5A5_3008, 32'h300C, 0);
        npc_op = 2'b00; branch = 1'b0;
        step();
        check_state("once", 32'h3004, 32'hA5A5_3000, 32'h3004, 0);

        // jr aligned.
        npc_op = 2'b11; rs_data = 32'h0000_3010;
        step();
        check_state("jr_ok", 32'h3010, 32'hA5A5_3004, 32'h3008, 0);
        npc_op = 2'b00;
        step();
        check_state("jr_seq", 32'h3014, 32'hA5A5_3010, 32'h3014, 0);

        // jr misaligned: target rounded down, error sticky.
        npc_op = 2'b11; rs_data = 32'h0000_3012;
        step();
        check_state("jr_bad", 32'h3010, 32'hA5A5_3014, 32'h3018, 1);
        npc_op = 2'b00;
        step();
        check_state("sticky", 32'h3014, 32'hA5A5_3010, 32'h3014, 1);

        // Async reset in the middle of a stalled jr.
        stall = 1'b1; npc_op = 2'b11; rs_data = 32'h0000_3012;
        step();
        check_state("stall_jr", 32'h3014, 32'hA5A5_3010, 32'h3014, 1);
        #2 reset = 1'b0;
        #1;
        check_state("async_rst", 32'h3000, 32'h0, 32'h3000, 0);
        #1 reset = 1'b1;
        stall = 1'b0; npc_op = 2'b00;
        check({"first_fetch", ".pcf"}, pcf, 32'h3000);
        step();
        check_state("post_rst", 32'h3004, 32'hA5A5_3000, 32'h3004, 0);

        // Misaligned jr under stall must not set the error.
        stall = 1'b1; npc_op = 2'b11; rs_data = 32'h0000_3012;
        step();
        check_state("stall_noerr", 32'h3004, 32'hA5A5_3000, 32'h3004, 0);

        // j to 0x4000 (just past the window): PCF moves, next fetch is a nop.
        stall = 1'b0; npc_op = 2'b10; imm26 = 26'h000_1000;
        step();
        check_state("j_oow", 32'h4000, 32'hA5A5_3004, 32'h3008, 0);
        npc_op = 2'b00;
        step();
        check_state("oow_nop", 32'h4004, 32'h0, 32'h4004, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_npc_unit.md
Name: fetch_npc_unit

Overview:
- IF stage and IF/ID pipeline register of the P6 five-stage MIPS pipeline.
- Holds the PC and forms the next-PC: sequential, conditional branch, j/jal, or jr.
- Consumes the one-bit branch decision that the ID-stage branch comparator produces on the same cycle.
- Latches the fetched instruction and link values into the ID stage. Architectural delay slot: no flush on redirect.

Parameters:
- PC_RESET, 32'h0000_3000, PC value loaded on reset.
- IM_BYTES, 32'h0000_1000, size of instruction memory in bytes; legal fetch window is [PC_RESET, PC_RESET+IM_BYTES).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- Stall  input  1  from hazard unit; 1 freezes PC and the IF/ID register.
- NPCOp  input  2  from ID decoder: 00 seq, 01 branch, 10 j/jal, 11 jr.
- Branch  input  1  branch-taken decision from the ID-stage comparator; only meaningful when NPCOp=01.
- Imm26  input  26  IR_D[25:0]; the low 16 bits are the branch offset, all 26 bits are the jump index.
- RSData  input  32  forwarded GPR[rs] in ID, used as the jr target.
- InstrF  input  32  instruction-memory read data at PCF (combinational IM).
- PCF  output  32  current fetch address, which drives the IM.
- IR_D  output  32  instruction register into ID.
- PC4_D  output  32  PC+4 of the instruction in ID.
- PC8_D  output  32  PC+8 of the instruction in ID (jal/jalr link).
- AddrErr  output  1  sticky flag: fetch attempted outside the legal window or to a misaligned address.

Behaviour:
- Reset (reset=0, asynchronous, any time including mid-stall):
  - PCF=PC_RESET; IR_D=0; PC4_D=PC_RESET; PC8_D=PC_RESET+4; AddrErr=0.
  - Release is synchronous to the next rising clk edge. The first fetch is PC_RESET.
- Next-PC is combinational, using PC4_D (the ID instruction's PC+4):
  - 00: NPC=PCF+4.
  - 01: NPC = PC4_D + (signext(Imm26[15:0])<<2) if Branch=1, else PCF+4.
  - 10: NPC = {PC4_D[31:28], Imm26, 2'b00}.
  - 11: NPC = {RSData[31:2], 2'b00}. If RSData[1:0]!=0, set AddrErr.
- Arithmetic is 32-bit and wraps modulo 2^32; overflow is not detected.
- Rising edge with Stall=0:
  - PCF<=NPC.
  - IR_D<=fetched word; PC4_D<=PCF+4; PC8_D<=PCF+8.
  - The redirect takes effect one cycle after the branch or jump enters ID. The instruction fetched during that cycle (the delay slot) enters ID normally.
- Rising edge with Stall=1:
  - PCF, IR_D, PC4_D and PC8_D hold.
  - The redirect is not applied. The branch remains in ID and is re-evaluated next cycle with fresh forwarded operands.
  - A Branch value seen during a stall has no lasting effect.
- Fetch window check:
  - Triggers if PCF<PC_RESET, or PCF>=PC_RESET+IM_BYTES, or PCF[1:0]!=0.
  - On trigger, the fetched word is forced to 32'h0 (nop) instead of InstrF, and AddrErr sets.
- AddrErr is sticky: it is set on the first unstalled clock edge where the condition holds, and only reset clears it. It does not set while Stall=1.
- Simultaneous events:
  - Stall dominates redirect.
  - Reset dominates everything.
  - NPCOp other than 01 ignores Branch.
- No combinational path from InstrF to any output. All outputs are registered except PCF, which is itself a register.

Test Plan:
- Reset, then release, no stall, NPCOp=00 for 4 cycles -> PCF steps 0x3000, 0x3004, 0x3008, 0x300C. IR_D lags InstrF by one cycle. PC8_D = PC4_D+4.
- Taken branch:
  - Setup: beq in ID with PC4_D=0x3008, Imm=0xFFFE, NPCOp=01, Branch=1.
  - Required: next PCF=0x3000; the delay slot at 0x3008 enters ID.
  - Repeat with Branch=0: next PCF=PCF+4.
- Branch under stall:
  - Stall=1 for 2 cycles with NPCOp=01 and Branch toggling 1,0 -> all registers hold.
  - Release with Branch=1 -> redirect applied exactly once.
- jr:
  - RSData=0x0000_3010 -> PCF=0x3010, AddrErr=0.
  - RSData=0x0000_3012 -> PCF=0x3010, AddrErr=1 and stays 1 until reset.
- Out-of-window jump: j to index giving 0x0000_4000 with IM_BYTES=0x1000 -> PCF=0x4000, IR_D=0 next cycle, AddrErr=1.
- Async reset asserted mid-cycle during a stalled jr -> outputs go to reset values immediately without waiting for clk. The first fetch after release is 0x3000.
